// File: rtl/zint_ack_if.sv
// Bus bundle between the Z80 strobes / ~INT generator and zint_ack.
// master: CPU bus plus generator side; slave: the acknowledge decoder.
interface zint_ack_if #(
  parameter int unsigned NEST_W = 3
);
  logic              m1_n;
  logic              iorq_n;
  logic              mreq_n;
  logic              rd_n;
  logic [7:0]        din;
  logic              int_n;
  logic [7:0]        im2vect;
  logic              intack;
  logic [7:0]        dout;
  logic              dout_oe;
  logic              in_service;
  logic [NEST_W-1:0] nest_depth;
  logic              reti_pulse;

  modport master (
    output m1_n, iorq_n, mreq_n, rd_n, din, int_n, im2vect,
    input  intack, dout, dout_oe, in_service, nest_depth, reti_pulse
  );

  modport slave (
    input  m1_n, iorq_n, mreq_n, rd_n, din, int_n, im2vect,
    output intack, dout, dout_oe, in_service, nest_depth, reti_pulse
  );
endinterface

// File: rtl/zint_ack.sv
// zint_ack: Z80 IM2 interrupt-acknowledge decoder.
// Decodes INTA (M1 with IORQ), raises intack to the ~INT generator, and drives
// the returned vector (or FLOAT_VEC when ~INT was already released) onto dout.
// Optional RETI tracking (ED 4D opcode fetches) with an ISR nesting counter is
// compiled in by defining ZINT_ACK_RETI_EN; otherwise din is ignored and the
// nesting outputs are tied low.
module zint_ack #(
  parameter int unsigned NEST_W    = 3,
  parameter logic [7:0]  FLOAT_VEC = 8'hFF
) (
  input logic       clk,
  input logic       res,
  zint_ack_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    DRIVE,
    RELEASE
  } state_t;

  state_t     state;
  logic       lost;
  logic       intack_r;
  logic       dout_oe_r;
  logic [7:0] dout_r;
  logic       inta;
  logic       ack_done;

  assign inta     = !bus.m1_n && !bus.iorq_n;
  // A completed acknowledge is the DRIVE->RELEASE transition.
  assign ack_done = (state == DRIVE) && bus.iorq_n;

  // Acknowledge FSM with registered intack / vector / output enable.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      lost      <= 1'b0;
      intack_r  <= 1'b0;
      dout_oe_r <= 1'b0;
      dout_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inta) begin
            state    <= LATCH;
            intack_r <= 1'b1;
            lost     <= bus.int_n;
          end
        end
        LATCH: begin
          if (inta) begin
            state     <= DRIVE;
            dout_r    <= lost ? FLOAT_VEC : bus.im2vect;
            dout_oe_r <= 1'b1;
          end else begin
            state    <= RELEASE;
            intack_r <= 1'b0;
          end
        end
        DRIVE: begin
          if (bus.iorq_n) begin
            state     <= RELEASE;
            intack_r  <= 1'b0;
            dout_oe_r <= 1'b0;
          end
        end
        RELEASE: begin
          if (bus.m1_n && bus.iorq_n) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          intack_r  <= 1'b0;
          dout_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.intack  = intack_r;
  assign bus.dout    = dout_r;
  assign bus.dout_oe = dout_oe_r;

`ifdef ZINT_ACK_RETI_EN
  localparam logic [NEST_W-1:0] NEST_MAX = '1;

  logic              fetch;
  logic              fetch_q;
  logic [7:0]        op_q;
  logic              prefix;
  logic              fetch_end;
  logic              reti_det;
  logic              reti_q;
  logic [NEST_W-1:0] nest;

  assign fetch     = !bus.m1_n && !bus.mreq_n && !bus.rd_n;
  assign fetch_end = fetch_q && !fetch;
  assign reti_det  = fetch_end && prefix && (op_q == 8'h4D);

  // Opcode capture, ED-prefix tracking and saturating nesting counter.
  // Increment and decrement in the same clock cancel out, so each branch
  // excludes the other event rather than applying both.
  always_ff @(posedge clk) begin
    if (res) begin
      fetch_q <= 1'b0;
      op_q    <= '0;
      prefix  <= 1'b0;
      reti_q  <= 1'b0;
      nest    <= '0;
    end else begin
      fetch_q <= fetch;
      if (fetch) begin
        op_q <= bus.din;
      end
      if (fetch_end) begin
        prefix <= (op_q == 8'hED);
      end
      reti_q <= reti_det;
      if (ack_done && !reti_det) begin
        if (nest != NEST_MAX) begin
          nest <= nest + 1'b1;
        end
      end else if (reti_det && !ack_done) begin
        if (nest != '0) begin
          nest <= nest - 1'b1;
        end
      end
    end
  end

  assign bus.reti_pulse = reti_q;
  assign bus.nest_depth = nest;
  assign bus.in_service = (nest != '0);
`else
  assign bus.reti_pulse = 1'b0;
  assign bus.nest_depth = '0;
  assign bus.in_service = 1'b0;
`endif

endmodule

// File: tb/tb_zint_ack.sv
// Scoreboard bench for zint_ack: stimulus pushes expected vectors and expected
// post-RETI nesting depths into queues; a monitor pops them when dout_oe rises
// or reti_pulse fires. Nesting is modelled as a plain saturating integer and the
// RETI prefix as "previous fetched opcode was ED".
module tb_zint_ack;

  localparam int unsigned NW = 3;
  localparam logic [7:0]  FV = 8'hFF;

  logic clk;
  logic res;

  zint_ack_if #(.NEST_W(NW)) bus ();

  zint_ack #(.NEST_W(NW), .FLOAT_VEC(FV)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [7:0]  exp_vec_q  [$];
  int unsigned exp_nest_q [$];
  int unsigned model_nest = 0;
  logic [7:0]  last_op    = 8'h00;
  logic [7:0]  cur_vec    = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned nest_max();
`ifdef ZINT_ACK_RETI_EN
    return (1 << NW) - 1;
`else
    return 0;
`endif
  endfunction

  function automatic void model_inc();
    if (model_nest < nest_max()) model_nest++;
  endfunction

  function automatic void model_fetch(input logic [7:0] op);
`ifdef ZINT_ACK_RETI_EN
    if (last_op == 8'hED && op == 8'h4D) begin
      if (model_nest > 0) model_nest--;
      exp_nest_q.push_back(model_nest);
    end
`endif
    last_op = op;
  endfunction

  // Generator model: vector is only valid while intack is seen high.
  always @(posedge clk) begin
    #1;
    bus.im2vect = bus.intack ? cur_vec : ~cur_vec;
  end

  // Monitor: vector scoreboard on dout_oe rising, RETI scoreboard on reti_pulse.
  initial begin
    logic       oe_prev;
    logic       reti_prev;
    logic [7:0] held;
    logic [7:0] v;
    oe_prev   = 1'b0;
    reti_prev = 1'b0;
    held      = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.dout_oe && !oe_prev) begin
        if (exp_vec_q.size() == 0) begin
          check("unexpected_oe", 1, 0);
        end else begin
          v = exp_vec_q.pop_front();
          check("vector", bus.dout, v);
          check("intack_with_oe", bus.intack, 1);
        end
        held = bus.dout;
      end else if (bus.dout_oe && oe_prev) begin
        check("dout_stable", bus.dout, held);
      end
      if (bus.reti_pulse && !reti_prev) begin
        if (exp_nest_q.size() == 0) begin
          check("unexpected_reti", 1, 0);
        end else begin
          check("reti_nest", bus.nest_depth, exp_nest_q.pop_front());
        end
      end
      if (reti_prev) check("reti_width", bus.reti_pulse, 0);
      oe_prev   = bus.dout_oe;
      reti_prev = bus.reti_pulse;
    end
  end

  task automatic idle_bus();
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.mreq_n = 1'b1; bus.rd_n = 1'b1;
  endtask

  task automatic check_nest(input string name);
    check(name, bus.nest_depth, model_nest);
    check({name, "_insvc"}, bus.in_service, (model_nest != 0));
  endtask

  task automatic do_ack(input logic intn, input logic [7:0] vec, input int unsigned hold);
    bus.int_n = intn;
    cur_vec   = vec;
    exp_vec_q.push_back(intn ? FV : vec);
    model_inc();
    @(posedge clk); #1 bus.m1_n = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1 bus.iorq_n = 1'b1;
    @(posedge clk); #1 bus.m1_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ack_intack_low", bus.intack, 0);
    check("ack_oe_low", bus.dout_oe, 0);
    check_nest("ack_nest");
  endtask

  task automatic do_fetch(input logic [7:0] op);
    model_fetch(op);
    @(posedge clk); #1;
    bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.din = op ^ 8'h3C;
    @(posedge clk); #1 bus.din = op;
    @(posedge clk); #1 idle_bus(); bus.din = 8'($urandom);
    repeat (2) @(posedge clk);
    #1 check_nest("fetch_nest");
  endtask

  task automatic do_abort();
    bus.int_n = 1'($urandom);
    cur_vec   = 8'($urandom);
    @(posedge clk); #1 bus.m1_n = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b1;
    @(negedge clk); check("abort_latch_intack", bus.intack, 1);
    @(negedge clk); check("abort_release_intack", bus.intack, 0);
    @(posedge clk); #1 bus.m1_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_nest("abort_nest");
  endtask

  task automatic do_plain_io();
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.intack;
    end
    check("plainio_intack", seen, 0);
    @(posedge clk); #1 bus.iorq_n = 1'b1;
  endtask

`ifdef ZINT_ACK_RETI_EN
  // Ack completes on the same edge as the ED 4D fetch ends.
  task automatic ack_with_reti();
    do_fetch(8'hED);
    bus.int_n = 1'b0;
    cur_vec   = 8'($urandom);
    exp_vec_q.push_back(cur_vec);
    exp_nest_q.push_back(model_nest);
    last_op = 8'h4D;
    @(posedge clk); #1 bus.m1_n = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.din = 8'h4D;
    @(posedge clk); #1 bus.iorq_n = 1'b1; bus.mreq_n = 1'b1; bus.rd_n = 1'b1;
    @(posedge clk); #1 bus.m1_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_nest("simul_nest");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.din     = 8'h00;
    bus.int_n   = 1'b1;
    bus.im2vect = 8'h00;
    res = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_intack", bus.intack, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_oe", bus.dout_oe, 0);
    check("rst_nest", bus.nest_depth, 0);
    check("rst_insvc", bus.in_service, 0);
    check("rst_reti", bus.reti_pulse, 0);
    @(posedge clk); #1 res = 1'b0;
    repeat (2) @(posedge clk);

    // Directed ack with explicit latency checks, iorq_n low for 4 clk.
    bus.int_n = 1'b0;
    cur_vec   = 8'hFD;
    exp_vec_q.push_back(8'hFD);
    model_inc();
    @(posedge clk); #1 bus.m1_n = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b0;
    @(negedge clk); check("t1_intack_pre", bus.intack, 0);
    @(negedge clk); check("t1_intack_rise", bus.intack, 1);
    check("t1_oe_pre", bus.dout_oe, 0);
    @(negedge clk); check("t1_oe", bus.dout_oe, 1);
    check("t1_dout", bus.dout, 8'hFD);
    @(posedge clk);
    @(posedge clk); #1 bus.iorq_n = 1'b1;
    @(negedge clk); check("t1_oe_held", bus.dout_oe, 1);
    @(negedge clk); check("t1_oe_drop", bus.dout_oe, 0);
    check("t1_intack_drop", bus.intack, 0);
    @(posedge clk); #1 bus.m1_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_nest("t1_nest");

    // Lost interrupt: floating vector.
    do_ack(1'b1, 8'hFB, 3);

    // RETI decoding.
    do_fetch(8'hED); do_fetch(8'h4D);
    do_ack(1'b0, 8'h10, 2);
    do_fetch(8'hED); do_fetch(8'hED); do_fetch(8'h4D);
    do_ack(1'b0, 8'h20, 2);
    do_fetch(8'hED); do_fetch(8'h00); do_fetch(8'h4D);

    // Saturation at both ends.
    for (int unsigned i = 0; i < 9; i++) do_ack(1'($urandom), 8'($urandom), 2 + $urandom_range(0, 2));
    for (int unsigned i = 0; i < 10; i++) begin
      do_fetch(8'hED); do_fetch(8'h4D);
    end
`ifdef ZINT_ACK_RETI_EN
    do_ack(1'b0, 8'h33, 2);
    ack_with_reti();
`endif

    // Reset while driving the vector.
    do_ack(1'b0, 8'h44, 2);
    bus.int_n = 1'b0;
    cur_vec   = 8'h5E;
    exp_vec_q.push_back(8'h5E);
    @(posedge clk); #1 bus.m1_n = 1'b0;
    @(posedge clk); #1 bus.iorq_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 res = 1'b1;
    @(negedge clk); check("t5_pre_oe", bus.dout_oe, 1);
    @(negedge clk);
    check("t5_intack", bus.intack, 0);
    check("t5_oe", bus.dout_oe, 0);
    check("t5_dout", bus.dout, 0);
    check("t5_nest", bus.nest_depth, 0);
    #1 res = 1'b0; idle_bus();
    model_nest = 0;
    last_op    = 8'h00;
    repeat (2) @(posedge clk);
    do_ack(1'b0, 8'hA7, 2);

    // Plain I/O and aborted INTA.
    do_plain_io();
    do_abort();

    // Randomised mix.
    for (int unsigned i = 0; i < 60; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 3) do_ack(1'($urandom), 8'($urandom), 2 + $urandom_range(0, 3));
      else if (r == 4) do_abort();
      else if (r == 5) do_plain_io();
      else begin
        case ($urandom_range(0, 2))
          0: do_fetch(8'hED);
          1: do_fetch(8'h4D);
          default: do_fetch(8'($urandom));
        endcase
      end
    end

    repeat (3) @(posedge clk);
    check("vec_q_empty", exp_vec_q.size(), 0);
    check("reti_q_empty", exp_nest_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
